// File: rtl/calendar_set_ctrl.sv
// Button-driven date editor. It walks year, month and day, then commits the edited date
// to the calendar as a one-cycle overwrite strobe.
module calendar_set_ctrl #(
    parameter int YEARRES     = 12,
    parameter int YEAR_MIN    = 2000,
    parameter int YEAR_MAX    = 2099,
    parameter int TIMEOUT_CYC = 1000,
    parameter int BLINK_HALF  = 250
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode_btn,
    input  logic               inc_btn,
    input  logic               dec_btn,
    input  logic [YEARRES+8:0] cur_date,
    output logic               date_ow,
    output logic [YEARRES+8:0] date_out,
    output logic [1:0]         edit_field,
    output logic               blink
);

    localparam logic [YEARRES-1:0] Y_MIN   = YEARRES'(YEAR_MIN);
    localparam logic [YEARRES-1:0] Y_MAX   = YEARRES'(YEAR_MAX);
    localparam logic [19:0]        TO_LAST = 20'(TIMEOUT_CYC - 1);
    localparam logic [15:0]        BL_LAST = 16'(BLINK_HALF - 1);

    typedef enum logic [2:0] {IDLE, SET_YEAR, SET_MONTH, SET_DAY, COMMIT} state_t;

    state_t             state;
    logic [2:0]         btn_q;
    logic [2:0]         btn_arm;
    logic [2:0]         btn_ev;
    logic               mode_ev, inc_ev, dec_ev, any_ev;
    logic [YEARRES-1:0] edit_year, year_nxt;
    logic [3:0]         edit_month, month_nxt;
    logic [4:0]         edit_day, day_nxt, mlen;
    logic [19:0]        idle_cnt;
    logic [15:0]        blink_cnt;

    function automatic logic [4:0] month_len(input logic [YEARRES-1:0] y, input logic [3:0] m);
        case (m)
            4'd2:                   month_len = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            default:                month_len = 5'd31;
        endcase
    endfunction

    // A button is armed only after it has been seen low since reset, so a level held
    // through reset release cannot fire.
    assign btn_ev  = {mode_btn, inc_btn, dec_btn} & ~btn_q & btn_arm;
    assign mode_ev = btn_ev[2];
    assign inc_ev  = btn_ev[1] & ~btn_ev[0] & ~btn_ev[2];
    assign dec_ev  = btn_ev[0] & ~btn_ev[1] & ~btn_ev[2];
    assign any_ev  = |btn_ev;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        year_nxt  = edit_year;
        month_nxt = edit_month;
        day_nxt   = edit_day;
        mlen      = month_len(edit_year, edit_month);
        if (inc_ev) begin
            year_nxt  = (edit_year < Y_MIN || edit_year >= Y_MAX) ? Y_MIN : edit_year + YEARRES'(1);
            month_nxt = (edit_month == 4'd0 || edit_month >= 4'd12) ? 4'd1 : edit_month + 4'd1;
            day_nxt   = (edit_day == 5'd0 || edit_day >= mlen) ? 5'd1 : edit_day + 5'd1;
        end else if (dec_ev) begin
            year_nxt  = (edit_year < Y_MIN || edit_year > Y_MAX) ? Y_MIN :
                        (edit_year == Y_MIN) ? Y_MAX : edit_year - YEARRES'(1);
            month_nxt = (edit_month == 4'd0 || edit_month > 4'd12) ? 4'd1 :
                        (edit_month == 4'd1) ? 4'd12 : edit_month - 4'd1;
            day_nxt   = (edit_day == 5'd0 || edit_day > mlen) ? 5'd1 :
                        (edit_day == 5'd1) ? mlen : edit_day - 5'd1;
        end
    end

    // NOTE: all state uses non-blocking assignments; later assignments in the block override earlier defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the edit registers are reset too, so a session never starts from X.
            state      <= IDLE;
            btn_q      <= 3'b000;
            btn_arm    <= 3'b000;
            edit_year  <= '0;
            edit_month <= '0;
            edit_day   <= '0;
            idle_cnt   <= '0;
            blink_cnt  <= '0;
            date_ow    <= 1'b0;
            date_out   <= '0;
            edit_field <= 2'd0;
            blink      <= 1'b0;
        end else begin
            btn_q   <= {mode_btn, inc_btn, dec_btn};
            btn_arm <= btn_arm | ~{mode_btn, inc_btn, dec_btn};
            date_ow <= 1'b0;
            case (state)
                IDLE: begin
                    edit_field <= 2'd0;
                    blink      <= 1'b0;
                    idle_cnt   <= '0;
                    blink_cnt  <= '0;
                    if (mode_ev) begin
                        {edit_year, edit_month, edit_day} <= cur_date;
                        state      <= SET_YEAR;
                        edit_field <= 2'd1;
                        blink      <= 1'b1;
                    end
                end
                SET_YEAR, SET_MONTH, SET_DAY: begin
                    idle_cnt <= any_ev ? 20'd0 : idle_cnt + 20'd1;
                    if (inc_ev || dec_ev) begin
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                    end else if (blink_cnt == BL_LAST) begin
                        blink     <= ~blink;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 16'd1;
                    end

                    if (mode_ev) begin
                        case (state)
                            SET_YEAR: begin
                                state      <= SET_MONTH;
                                edit_field <= 2'd2;
                            end
                            SET_MONTH: begin
                                state      <= SET_DAY;
                                edit_field <= 2'd3;
                                if (edit_day > mlen) edit_day <= mlen;
                            end
                            default: begin
                                state      <= COMMIT;
                                edit_field <= 2'd0;
                                blink      <= 1'b0;
                                date_ow    <= 1'b1;
                                date_out   <= {edit_year, edit_month, edit_day};
                            end
                        endcase
                    end else if (!any_ev && idle_cnt == TO_LAST) begin
                        state      <= IDLE;
                        edit_field <= 2'd0;
                        blink      <= 1'b0;
                        idle_cnt   <= '0;
                        blink_cnt  <= '0;
                    end else begin
                        case (state)
                            SET_YEAR:  edit_year  <= year_nxt;
                            SET_MONTH: edit_month <= month_nxt;
                            default:   edit_day   <= day_nxt;
                        endcase
                    end
                end
                COMMIT: begin
                    state      <= IDLE;
                    edit_field <= 2'd0;
                    blink      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Directed bench for calendar_set_ctrl: session walks, field wraps, clamping, timeout,
// blink timing and mid-session reset with a held button.
module tb_calendar_set_ctrl;

    localparam int YR = 12;
    localparam int DW = YR + 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode_btn, inc_btn, dec_btn;
    logic [DW-1:0] cur_date;
    logic          date_ow;
    logic [DW-1:0] date_out;
    logic [1:0]    edit_field;
    logic          blink;

    int errors = 0;
    int checks = 0;

    calendar_set_ctrl #(
        .YEARRES(YR), .YEAR_MIN(2000), .YEAR_MAX(2099), .TIMEOUT_CYC(10), .BLINK_HALF(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .cur_date(cur_date), .date_ow(date_ow), .date_out(date_out),
        .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pk(input int y, input int m, input int d);
        return {YR'(y), 4'(m), 5'(d)};
    endfunction

    // One press: level high across one rising edge, then released.
    task automatic press(input logic m, input logic i, input logic d);
        @(negedge clk); mode_btn = m; inc_btn = i; dec_btn = d;
        @(negedge clk); mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    endtask

    task automatic start(input logic [DW-1:0] d);
        cur_date = d;
        press(1'b1, 1'b0, 1'b0);
    endtask

    // Final mode press from SET_DAY; samples the strobe and the cycle after it.
    task automatic commit(output logic ow, output logic [DW-1:0] dout, output logic ow_next);
        press(1'b1, 1'b0, 1'b0);
        ow   = date_ow;
        dout = date_out;
        @(negedge clk);
        ow_next = date_ow;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0; cur_date = '0;
        repeat (3) @(negedge clk);
        checks++; if (date_ow !== 1'b0) begin errors++; $display("FAIL reset_ow: got %0b want 0", date_ow); end
        checks++; if (date_out !== '0) begin errors++; $display("FAIL reset_out: got %0h want 0", date_out); end
        checks++; if (edit_field !== 2'd0) begin errors++; $display("FAIL reset_field: got %0d want 0", edit_field); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %0b want 0", blink); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_ignore;
        cur_date = pk(2024, 5, 5);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++; if (edit_field !== 2'd0) begin errors++; $display("FAIL idle_incdec_field: got %0d want 0", edit_field); end
        checks++; if (date_ow !== 1'b0) begin errors++; $display("FAIL idle_incdec_ow: got %0b want 0", date_ow); end
    endtask

    task automatic test_leap_clamp;
        logic ow, ow_n; logic [DW-1:0] dout;
        start(pk(2024, 2, 29));
        checks++; if (edit_field !== 2'd1) begin errors++; $display("FAIL leap_enter_year: got %0d want 1", edit_field); end
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (edit_field !== 2'd2) begin errors++; $display("FAIL leap_month_field: got %0d want 2", edit_field); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (edit_field !== 2'd3) begin errors++; $display("FAIL leap_day_field: got %0d want 3", edit_field); end
        commit(ow, dout, ow_n);
        checks++; if (ow !== 1'b1) begin errors++; $display("FAIL leap_ow: got %0b want 1", ow); end
        checks++; if (dout !== pk(2025, 2, 28)) begin errors++; $display("FAIL leap_out: got %0h want %0h", dout, pk(2025, 2, 28)); end
        checks++; if (ow_n !== 1'b0) begin errors++; $display("FAIL leap_ow_one_cycle: got %0b want 0", ow_n); end
        checks++; if (date_out !== pk(2025, 2, 28)) begin errors++; $display("FAIL leap_out_hold: got %0h want %0h", date_out, pk(2025, 2, 28)); end
        checks++; if (edit_field !== 2'd0) begin errors++; $display("FAIL leap_back_idle: got %0d want 0", edit_field); end
    endtask

    task automatic test_year_wrap;
        logic ow, ow_n; logic [DW-1:0] dout;
        start(pk(2099, 7, 31)); press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2000, 7, 31)) begin errors++; $display("FAIL year_inc_wrap: got %0h want %0h", dout, pk(2000, 7, 31)); end
        start(pk(2099, 7, 31)); press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2099, 7, 31)) begin errors++; $display("FAIL year_dec_wrap: got %0h want %0h", dout, pk(2099, 7, 31)); end
        start(pk(1999, 3, 5)); press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2000, 3, 5)) begin errors++; $display("FAIL year_out_of_range: got %0h want %0h", dout, pk(2000, 3, 5)); end
    endtask

    task automatic test_month;
        logic ow, ow_n; logic [DW-1:0] dout;
        start(pk(2023, 1, 31)); press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1); press(1'b0, 1'b1, 1'b1);
        press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2023, 12, 31)) begin errors++; $display("FAIL month_dec_wrap: got %0h want %0h", dout, pk(2023, 12, 31)); end
        start(pk(2023, 12, 10)); press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2023, 1, 10)) begin errors++; $display("FAIL month_inc_wrap: got %0h want %0h", dout, pk(2023, 1, 10)); end
        start(pk(2023, 14, 10)); press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2023, 1, 10)) begin errors++; $display("FAIL month_forced: got %0h want %0h", dout, pk(2023, 1, 10)); end
        start(pk(2023, 3, 31)); press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2023, 4, 30)) begin errors++; $display("FAIL april_clamp: got %0h want %0h", dout, pk(2023, 4, 30)); end
    endtask

    task automatic test_day;
        logic ow, ow_n; logic [DW-1:0] dout;
        start(pk(2023, 4, 30)); press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2023, 4, 1)) begin errors++; $display("FAIL day_inc_wrap: got %0h want %0h", dout, pk(2023, 4, 1)); end
        start(pk(2024, 2, 1)); press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2024, 2, 29)) begin errors++; $display("FAIL day_dec_leap: got %0h want %0h", dout, pk(2024, 2, 29)); end
        start(pk(2023, 6, 0)); press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2023, 6, 1)) begin errors++; $display("FAIL day_zero_forced: got %0h want %0h", dout, pk(2023, 6, 1)); end
    endtask

    task automatic test_mode_priority;
        logic ow, ow_n; logic [DW-1:0] dout;
        start(pk(2050, 5, 5));
        press(1'b1, 1'b1, 1'b0);
        checks++; if (edit_field !== 2'd2) begin errors++; $display("FAIL prio_field: got %0d want 2", edit_field); end
        press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2050, 5, 5)) begin errors++; $display("FAIL prio_year_kept: got %0h want %0h", dout, pk(2050, 5, 5)); end
    endtask

    task automatic test_blink;
        start(pk(2030, 1, 1));
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_entry: got %0b want 1", blink); end
        repeat (2) @(negedge clk);
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_hold: got %0b want 1", blink); end
        @(negedge clk);
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_toggle: got %0b want 0", blink); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_force: got %0b want 1", blink); end
        repeat (3) @(negedge clk);
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_after_force: got %0b want 0", blink); end
        repeat (10) @(negedge clk);
        checks++; if (edit_field !== 2'd0 || blink !== 1'b0) begin errors++; $display("FAIL blink_idle: field %0d blink %0b want 0 0", edit_field, blink); end
    endtask

    task automatic test_timeout;
        logic seen_ow = 1'b0;
        start(pk(2040, 8, 8)); press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (date_ow) seen_ow = 1'b1;
        end
        checks++; if (edit_field !== 2'd3) begin errors++; $display("FAIL timeout_early: got field %0d want 3", edit_field); end
        @(negedge clk);
        if (date_ow) seen_ow = 1'b1;
        checks++; if (edit_field !== 2'd0) begin errors++; $display("FAIL timeout_idle: got field %0d want 0", edit_field); end
        repeat (3) begin @(negedge clk); if (date_ow) seen_ow = 1'b1; end
        checks++; if (seen_ow !== 1'b0) begin errors++; $display("FAIL timeout_no_commit: got ow seen %0b want 0", seen_ow); end
    endtask

    task automatic test_reset_mid;
        logic ow, ow_n; logic [DW-1:0] dout;
        start(pk(2030, 6, 15)); press(1'b1, 1'b0, 1'b0);
        @(negedge clk); inc_btn = 1'b1; rst_n = 1'b0;
        #1;
        checks++; if ({date_ow, edit_field, blink} !== 4'b0 || date_out !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: ow %0b field %0d blink %0b out %0h want all 0", date_ow, edit_field, blink, date_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mode_btn = 1'b1;
        @(negedge clk); mode_btn = 1'b0;
        checks++; if (edit_field !== 2'd1) begin errors++; $display("FAIL reset_mid_enter: got %0d want 1", edit_field); end
        repeat (2) @(negedge clk);
        inc_btn = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0); commit(ow, dout, ow_n);
        checks++; if (dout !== pk(2031, 6, 15)) begin errors++; $display("FAIL reset_held_inc: got %0h want %0h", dout, pk(2031, 6, 15)); end
    endtask

    initial begin
        test_reset;
        test_idle_ignore;
        test_leap_clamp;
        test_year_wrap;
        test_month;
        test_day;
        test_mode_priority;
        test_blink;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calendar_set_ctrl.md
CALENDAR_SET_CTRL -- requirements
Module: calendar_set_ctrl

Interface
REQ-001 Parameter YEARRES, default 12: year field width in bits.
REQ-002 Parameter YEAR_MIN, default 2000: lowest settable year.
REQ-003 Parameter YEAR_MAX, default 2099: highest settable year.
REQ-004 Parameter TIMEOUT_CYC, default 1000: idle cycles before an edit session aborts; range 2 to 2^20-1.
REQ-005 Parameter BLINK_HALF, default 250: cycles per blink half-period; range 1 to 2^16-1.
REQ-006 Port clk, input, 1: system clock; all state updates on the rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port mode_btn, input, 1: debounced level; each rising edge advances the edit field.
REQ-009 Port inc_btn, input, 1: debounced level; each rising edge increments the active field.
REQ-010 Port dec_btn, input, 1: debounced level; each rising edge decrements the active field.
REQ-011 Port cur_date, input, YEARRES+9: live calendar date, packed {year, month[3:0], day[4:0]}.
REQ-012 Port date_ow, output, 1: single-cycle commit strobe to the calendar overwrite input.
REQ-013 Port date_out, output, YEARRES+9: edited date in the cur_date packing; valid while date_ow=1.
REQ-014 Port edit_field, output, 2: field under edit; 0=none, 1=year, 2=month, 3=day.
REQ-015 Port blink, output, 1: display blanking toggle for the active field; 0 when edit_field=0.

Function
REQ-016 Each button shall be registered once per cycle; an event is input=1 with the previous registered value 0; its effect shall be visible after that same clock edge.
REQ-017 FSM states: IDLE, SET_YEAR, SET_MONTH, SET_DAY, COMMIT.
REQ-018 In IDLE a mode event shall load edit_year, edit_month and edit_day from cur_date and enter SET_YEAR; inc and dec events in IDLE shall be ignored.
REQ-019 Mode events shall step SET_YEAR to SET_MONTH, SET_MONTH to SET_DAY, and SET_DAY to COMMIT.
REQ-020 COMMIT shall last exactly one cycle, drive date_ow=1 with date_out={edit_year, edit_month, edit_day}, then return to IDLE.
REQ-021 Year inc: YEAR_MAX wraps to YEAR_MIN. Year dec: YEAR_MIN wraps to YEAR_MAX. A loaded year outside the range shall be forced to YEAR_MIN on its first inc or dec.
REQ-022 Month inc: 12 wraps to 1. Month dec: 1 wraps to 12. Loaded values 0 or 13-15 shall be forced to 1 on the first inc or dec.
REQ-023 Month length: February is 29 days when edit_year[1:0]==0, otherwise 28; April, June, September and November are 30; all other months are 31.
REQ-024 Day inc: month length wraps to 1. Day dec: 1 wraps to month length. A value of 0 or above month length shall be forced to 1 on the first inc or dec.
REQ-025 On the SET_MONTH to SET_DAY transition, edit_day shall be clamped to the month length (e.g. 31 becomes 30 for April).
REQ-026 inc and dec events in the same cycle shall both be ignored.
REQ-027 A mode event in the same cycle as inc or dec shall take priority; the inc or dec shall be discarded.
REQ-028 A cycle counter shall clear on any button event and count while in SET_YEAR, SET_MONTH or SET_DAY.
REQ-029 When the counter reaches TIMEOUT_CYC-1, the FSM shall return to IDLE without asserting date_ow.
REQ-030 blink shall toggle every BLINK_HALF cycles while editing, restart at 1 on entry to SET_YEAR, and be forced to 1 on any inc or dec event.
REQ-031 date_ow shall be 0 in every state except COMMIT.
REQ-032 date_out shall hold the last committed value outside COMMIT.

Reset
REQ-033 Assertion of rst_n=0 shall immediately force IDLE, date_ow=0, date_out=0, edit_field=0 and blink=0, and clear the counters and button registers, including mid-session; no commit shall be issued.
REQ-034 After rst_n rises, a button already held high shall not produce an event until it is released and pressed again.

Verification
REQ-035 cur_date={2024,2,29}; press mode, inc (year 2025), mode, mode, mode -> day clamped to 28; date_ow is one cycle with date_out={2025,2,28}.
REQ-036 Year 2099; press mode, then inc -> 2100 wraps to 2000; press dec -> 1999 wraps to 2099.
REQ-037 In SET_MONTH with month=1, press dec -> 12; press inc and dec in the same cycle -> 12 unchanged.
REQ-038 TIMEOUT_CYC=10; enter SET_DAY with no further presses -> IDLE after 10 cycles; date_ow never asserts.
REQ-039 Pull rst_n low during SET_MONTH while holding inc_btn=1 -> all outputs 0 at once; after release of reset, no increment occurs until inc_btn is released and pressed again.
REQ-040 Press mode and inc in the same cycle while in SET_YEAR -> SET_MONTH entered; year unchanged.
